// File: rtl/msg_receiver.sv
// msg_receiver: 8N1 serial receiver with a single-entry hold register, frame/overrun flags.
// Optional even-parity bit when MSG_RX_PARITY_EN is defined (adds PARITY state and parity_err).
module msg_receiver #(
  parameter int CLKS_PER_BIT = 1250,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       data_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
`ifdef MSG_RX_PARITY_EN
  ,
  output logic       parity_err
`endif
);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
`ifdef MSG_RX_PARITY_EN
    ,
    PARITY
`endif
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             rx_m, rx_s, rx_prev;
  logic             ack_take;
  logic             bit_done;

  // Synchroniser and edge-detect history reset to the idle-line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m    <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_m    <= rx_in;
      rx_s    <= rx_m;
      rx_prev <= rx_s;
    end
  end

  assign ack_take = rx_ack && data_ready;
  assign bit_done = (cnt == BIT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      rx_data    <= '0;
      data_ready <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
`ifdef MSG_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
`ifdef MSG_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      if (ack_take) begin
        data_ready <= 1'b0;
        overrun    <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (rx_prev && !rx_s) begin
            state <= START;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end

        START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (!rx_s) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DATA: begin
          if (bit_done) begin
            cnt     <= '0;
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) begin
`ifdef MSG_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

`ifdef MSG_RX_PARITY_EN
        PARITY: begin
          if (bit_done) begin
            cnt <= '0;
            if (rx_s == ^shreg) begin
              state <= STOP;
            end else begin
              parity_err <= 1'b1;
              state      <= WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif

        STOP: begin
          if (bit_done) begin
            cnt <= '0;
            if (rx_s) begin
              state <= IDLE;
              busy  <= 1'b0;
              // An acknowledge in this same cycle frees the register for the new byte.
              if (!data_ready || ack_take) begin
                rx_data    <= shreg;
                data_ready <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // A line held low after a bad frame must not look like a new start edge.
        WAIT_HIGH: begin
          if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
